// File: rtl/exhaustive_vector_checker_pkg.sv
// Shared types and limits for the exhaustive vector checker.
package evc_pkg;

   typedef enum logic [1:0] {
      IDLE,
      APPLY,
      WAIT,
      DONE
   } evc_state_t;

   localparam int EVC_MAX_N_IN = 16;
   localparam int EVC_SETTLE_W = 8;

endpackage

// File: rtl/exhaustive_vector_checker_settle_timer.sv
// Loadable down-counter that holds at zero; paces the settle wait of each vector.
module evc_settle_timer
   import evc_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    load,
   input  logic [EVC_SETTLE_W-1:0] load_val,
   output logic                    zero
);

   logic [EVC_SETTLE_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/exhaustive_vector_checker.sv
// Sweeps all 2^N_IN input vectors, compares the DUT output against EXPECT and counts mismatches.
// Optional: define EXHAUSTIVE_VECTOR_CHECKER_STOP_ON_FAIL_EN to end the sweep at the first mismatch.
module exhaustive_vector_checker
   import evc_pkg::*;
#(
   parameter int N_IN   = 3,
   parameter     EXPECT = 8'b1110_1000,
   parameter int SETTLE = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            dut_out,
   output logic [N_IN-1:0] vec_out,
   output logic            busy,
   output logic            done,
   output logic            pass,
   output logic [N_IN:0]   err_count,
   output logic [N_IN-1:0] first_fail_idx,
   output logic            first_fail_valid
);

   localparam int unsigned              NVEC     = 1 << N_IN;
   localparam logic [NVEC-1:0]          EXP_V    = EXPECT;
   localparam logic [N_IN:0]            ERR_MAX  = NVEC[N_IN:0];
   localparam logic [EVC_SETTLE_W-1:0]  SETTLE_V = SETTLE[EVC_SETTLE_W-1:0];

   if ($bits(EXPECT) != (1 << N_IN)) begin : g_bad_expect_w
      $error("EXPECT must be 2^N_IN bits wide");
   end
   if (N_IN < 1 || N_IN > EVC_MAX_N_IN) begin : g_bad_n_in
      $error("N_IN out of range 1..16");
   end
   if (SETTLE < 0 || SETTLE > 255) begin : g_bad_settle
      $error("SETTLE out of range 0..255");
   end

   evc_state_t      state;
   logic [N_IN-1:0] idx;
   logic            tmr_zero;
   logic            mismatch;
   logic            last;
   logic            finish;
   logic [N_IN:0]   err_inc;
   logic [N_IN:0]   err_next;

   evc_settle_timer u_settle_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (state == APPLY),
      .load_val (SETTLE_V),
      .zero     (tmr_zero)
   );

   assign mismatch = dut_out ^ EXP_V[idx];
   assign last     = (idx == {N_IN{1'b1}});
   assign err_inc  = (err_count == ERR_MAX) ? err_count : err_count + 1'b1;
   assign err_next = mismatch ? err_inc : err_count;

`ifdef EXHAUSTIVE_VECTOR_CHECKER_STOP_ON_FAIL_EN
   assign finish = last | mismatch;
`else
   assign finish = last;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= IDLE;
         idx              <= '0;
         vec_out          <= '0;
         busy             <= 1'b0;
         done             <= 1'b0;
         pass             <= 1'b0;
         err_count        <= '0;
         first_fail_idx   <= '0;
         first_fail_valid <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  idx              <= '0;
                  err_count        <= '0;
                  pass             <= 1'b0;
                  first_fail_valid <= 1'b0;
                  busy             <= 1'b1;
                  state            <= APPLY;
               end
            end
            APPLY: begin
               vec_out <= idx;
               state   <= WAIT;
            end
            WAIT: begin
               // The compare happens only once the settle counter has run out.
               if (tmr_zero) begin
                  err_count <= err_next;
                  if (mismatch && !first_fail_valid) begin
                     first_fail_idx   <= idx;
                     first_fail_valid <= 1'b1;
                  end
                  if (finish) begin
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     pass  <= (err_next == '0);
                  end else begin
                     idx   <= idx + 1'b1;
                     state <= APPLY;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_exhaustive_vector_checker.sv
// Directed bench for exhaustive_vector_checker with a result scoreboard and a behavioural DUT model.
module tb_exhaustive_vector_checker;

   logic       clk = 1'b0;
   logic       rst_n, start, dut_out;
   logic [2:0] vec_out;
   logic       busy, done, pass, ffv;
   logic [3:0] err_count;
   logic [2:0] ffi;

   logic       start2, dut2_out;
   logic [0:0] vec2, ffi2;
   logic       busy2, done2, pass2, ffv2;
   logic [1:0] err2;

   int         mode;
   int         n_checks = 0;
   int         n_pass   = 0;
   int         n_fail   = 0;

   typedef struct {
      int lat;
      int last_vec;
      int err;
      int pass;
      int ffv;
      int ffi;
      int err4;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   exhaustive_vector_checker #(.N_IN(3), .EXPECT(8'b1110_1000), .SETTLE(2)) u_dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .start            (start),
      .dut_out          (dut_out),
      .vec_out          (vec_out),
      .busy             (busy),
      .done             (done),
      .pass             (pass),
      .err_count        (err_count),
      .first_fail_idx   (ffi),
      .first_fail_valid (ffv)
   );

   exhaustive_vector_checker #(.N_IN(1), .EXPECT(2'b10), .SETTLE(0)) u_dut2 (
      .clk              (clk),
      .rst_n            (rst_n),
      .start            (start2),
      .dut_out          (dut2_out),
      .vec_out          (vec2),
      .busy             (busy2),
      .done             (done2),
      .pass             (pass2),
      .err_count        (err2),
      .first_fail_idx   (ffi2),
      .first_fail_valid (ffv2)
   );

   // Unit under check: 3-input majority, optionally broken at vector 5 or fully inverted.
   always_comb begin
      dut_out = (vec_out[0] & vec_out[1]) | (vec_out[0] & vec_out[2]) | (vec_out[1] & vec_out[2]);
      if (mode == 1 && vec_out == 3'd5) dut_out = ~dut_out;
      if (mode == 2) dut_out = ~dut_out;
   end
   assign dut2_out = vec2[0];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic sweep(input string name, input exp_t e, input int restart_at);
      exp_t x;
      int   cyc, vbad;
      bit   seen;
      sb.push_back(e);
      @(negedge clk) start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      cyc  = 0;
      vbad = 0;
      seen = 0;
      while (!seen && cyc < 200) begin
         start = (restart_at != 0 && cyc == restart_at);
         @(posedge clk);
         #1;
         cyc++;
         if (done) seen = 1;
         if (cyc == 4) chk({name, "_err_at_first_compare"}, err_count, sb[0].err4);
         if (vec_out !== 3'((cyc - 1) / 4)) vbad++;
      end
      start = 1'b0;
      x = sb.pop_front();
      chk({name, "_latency"}, cyc, x.lat);
      chk({name, "_vec_sequence_bad"}, vbad, 0);
      chk({name, "_busy_at_done"}, busy, 0);
      chk({name, "_vec_at_done"}, vec_out, x.last_vec);
      chk({name, "_err_count"}, err_count, x.err);
      chk({name, "_pass"}, pass, x.pass);
      chk({name, "_ffv"}, ffv, x.ffv);
      if (x.ffv != 0) chk({name, "_ffi"}, ffi, x.ffi);
      @(posedge clk);
      #1;
      chk({name, "_done_single_pulse"}, done, 0);
      chk({name, "_err_held"}, err_count, x.err);
   endtask

   initial begin
      int cyc;
      bit saw_done;
      rst_n  = 1'b0;
      start  = 1'b0;
      start2 = 1'b0;
      mode   = 0;
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_vec_out", vec_out, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_pass", pass, 0);
      chk("rst_err", err_count, 0);
      chk("rst_ffi", ffi, 0);
      chk("rst_ffv", ffv, 0);

      mode = 0;
      sweep("good", '{lat: 32, last_vec: 7, err: 0, pass: 1, ffv: 0, ffi: 0, err4: 0}, 0);

      mode = 1;
`ifdef EXHAUSTIVE_VECTOR_CHECKER_STOP_ON_FAIL_EN
      sweep("bad5", '{lat: 24, last_vec: 5, err: 1, pass: 0, ffv: 1, ffi: 5, err4: 0}, 0);
`else
      sweep("bad5", '{lat: 32, last_vec: 7, err: 1, pass: 0, ffv: 1, ffi: 5, err4: 0}, 0);
`endif

      mode = 2;
`ifdef EXHAUSTIVE_VECTOR_CHECKER_STOP_ON_FAIL_EN
      sweep("inv", '{lat: 4, last_vec: 0, err: 1, pass: 0, ffv: 1, ffi: 0, err4: 1}, 0);
`else
      sweep("inv", '{lat: 32, last_vec: 7, err: 8, pass: 0, ffv: 1, ffi: 0, err4: 1}, 0);
`endif

      mode = 0;
      sweep("restart_ignored", '{lat: 32, last_vec: 7, err: 0, pass: 1, ffv: 0, ffi: 0, err4: 0}, 10);

      // Abort a sweep with errors already counted, then confirm a clean rerun.
      mode = 2;
      @(negedge clk) start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (14) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("abort_vec_out", vec_out, 0);
      chk("abort_busy", busy, 0);
      chk("abort_pass", pass, 0);
      chk("abort_err", err_count, 0);
      chk("abort_ffv", ffv, 0);
      chk("abort_ffi", ffi, 0);
      saw_done = 0;
      repeat (3) begin
         @(posedge clk);
         #1;
         if (done) saw_done = 1;
      end
      @(negedge clk) rst_n = 1'b1;
      repeat (20) begin
         @(posedge clk);
         #1;
         if (done) saw_done = 1;
      end
      chk("abort_no_done", saw_done, 0);
      mode = 0;
      sweep("after_abort", '{lat: 32, last_vec: 7, err: 0, pass: 1, ffv: 0, ffi: 0, err4: 0}, 0);

      // Single-input buffer with no settle time.
      @(negedge clk) start2 = 1'b1;
      @(posedge clk);
      #1 start2 = 1'b0;
      cyc = 0;
      while (!done2 && cyc < 50) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      chk("small_latency", cyc, 4);
      chk("small_pass", pass2, 1);
      chk("small_err", err2, 0);
      chk("small_ffv", ffv2, 0);
      chk("small_vec", vec2, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/exhaustive_vector_checker.md
# exhaustive_vector_checker

Self-checking sweep engine for small combinational blocks. On `start` it drives every one of the 2^N_IN input combinations in ascending binary order onto the DUT inputs. After a programmable settle time it samples the single DUT output and compares it against a parameterised expected truth table. It counts mismatches and reports pass/fail. It replaces hand-written exhaustive stimulus lists in lab benches, and it can also sit on-chip as a built-in check for a combinational cell.

## Interface
- `N_IN`, default 3: number of DUT inputs; legal range 1..16.
- `EXPECT`, default 8'b1110_1000: expected truth table, 2^N_IN bits wide; bit i is the expected output for input vector i.
- `SETTLE`, default 2: extra wait cycles between applying a vector and sampling; legal range 0..255.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a sweep; sampled only in IDLE or DONE.
- `dut_out`  in  1  DUT output under test.
- `vec_out`  out  N_IN  current input vector driven to the DUT.
- `busy`  out  1  high while a sweep is running.
- `done`  out  1  one-cycle pulse when a sweep completes.
- `pass`  out  1  high when the last completed sweep had zero mismatches; valid when not busy.
- `err_count`  out  N_IN+1  mismatch count of the current or last sweep.
- `first_fail_idx`  out  N_IN  index of the first mismatching vector.
- `first_fail_valid`  out  1  `first_fail_idx` holds a captured value.

## Operation
- The FSM has four states: IDLE, APPLY, WAIT, DONE.
- IDLE or DONE, with `start`=1:
  - `idx` is cleared to 0, and `err_count`, `pass` and `first_fail_valid` are cleared.
  - The FSM moves to APPLY and `busy` goes to 1.
- APPLY:
  - `vec_out`<=`idx`.
  - The settle counter is loaded with SETTLE.
  - The FSM moves to WAIT.
- WAIT, counter nonzero: the counter decrements.
- WAIT, counter zero: `dut_out` is sampled and compared with EXPECT[`idx`].
  - On mismatch, `err_count` increments. If `first_fail_valid`=0, `first_fail_idx`<=`idx` and `first_fail_valid`<=1.
  - If `idx`==2^N_IN-1, the FSM moves to DONE. Otherwise `idx` increments and the FSM returns to APPLY.
- Entering DONE:
  - `done` pulses high for one cycle and `busy` goes to 0.
  - `pass`<=(final `err_count`==0).
  - All results are held until the next accepted `start`.
- `start` while `busy`=1 is ignored.
- `start` held high in DONE immediately begins a new sweep; `done` has still pulsed for one cycle.
- `err_count` saturates at 2^N_IN. It is N_IN+1 bits wide, so saturation cannot occur in normal use.
- `idx` is N_IN bits wide. The sweep terminates on the all-ones compare and never wraps.

## Timing
- Reset values: `vec_out`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `first_fail_idx`=0, `first_fail_valid`=0; state IDLE.
- Reset asserted mid-sweep aborts immediately. All outputs return to their reset values, and no `done` pulse is produced.
- Per-vector period is SETTLE+2 cycles:
  - 1 APPLY cycle.
  - SETTLE+1 WAIT cycles.
- `dut_out` is therefore sampled at least SETTLE+1 cycles after `vec_out` changes.
- Sweep latency is 2^N_IN*(SETTLE+2) cycles, from the edge that accepts `start` to the edge that asserts `done`.
- For N_IN=3 and SETTLE=2, that is 32 cycles.
- `err_count` updates on the same edge as the compare. Outputs are registered, with no combinational path from `dut_out` to any output.

## Configuration
- Macro: `EXHAUSTIVE_VECTOR_CHECKER_STOP_ON_FAIL_EN`.
- Defined: the first mismatch ends the sweep.
  - The FSM goes straight to DONE on that compare edge.
  - `err_count`=1, `pass`=0, and `vec_out` holds the failing vector.
- Undefined: every vector is always swept and every mismatch is counted.

## Structure
- Package `evc_pkg` holds:
  - the state typedef `evc_state_t` (IDLE, APPLY, WAIT, DONE);
  - the constants `EVC_MAX_N_IN`=16 and `EVC_SETTLE_W`=8.
- Sub-module `evc_settle_timer` is a loadable down-counter with inputs load value and `load`, and output `zero`. It is instantiated once.
- Width checks (`$bits(EXPECT)`==2^N_IN, N_IN range) are elaboration-time assertions.

## Test plan
All scenarios use N_IN=3, EXPECT=8'b1110_1000 (majority) and SETTLE=2 unless stated otherwise.
1. Correct DUT model, pulse `start` -> `vec_out` steps 0..7, `done` 32 cycles after start, `pass`=1, `err_count`=0, `first_fail_valid`=0.
2. DUT forced wrong at vector 5 only -> `err_count`=1, `first_fail_idx`=5, `pass`=0. With STOP_ON_FAIL_EN: `done` after 24 cycles and `vec_out`=5.
3. DUT output constantly inverted -> `err_count`=8, `first_fail_idx`=0, `pass`=0.
4. `start` pulsed again at cycle 10 of a sweep -> ignored; `done` still at cycle 32 with a single pulse.
5. `rst_n` low at cycle 15 -> all outputs return to reset values asynchronously and no `done` pulse occurs. A later `start` completes normally.
6. SETTLE=0, N_IN=1, EXPECT=2'b10 with DUT as a buffer -> `done` after 4 cycles, `pass`=1.
